gcd_req: RTL and testbench
==========================

Name: gcd_req

Overview:
- Initiator side of the start/busy/valid operand interface used by the team's gcd core.
- Accepts operand pairs from an upstream valid/ready stream and issues each pair to the core as a one-cycle start pulse, holding the operands stable.
- Waits for the core's valid pulse with a watchdog timeout, then presents the result on a downstream valid/ready stream with an error flag.
- One job in flight at a time; sits between the command fabric and one gcd core instance.

Parameters:
- WIDTH, 32, operand and result width.
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT before the job is aborted (must be ≥2).
- CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- in_valid_i  input  1  upstream operand pair valid.
- in_ready_o  output  1  block can accept a pair.
- in_a_i  input  WIDTH  operand A.
- in_b_i  input  WIDTH  operand B.
- core_start_o  output  1  one-cycle start pulse to core.
- core_a_o  output  WIDTH  operand A to core.
- core_b_o  output  WIDTH  operand B to core.
- core_busy_i  input  1  core computing; monitored only.
- core_valid_i  input  1  core result valid, one-cycle pulse.
- core_result_i  input  WIDTH  core result.
- out_valid_o  output  1  result available downstream.
- out_ready_i  input  1  downstream accepts result.
- out_result_o  output  WIDTH  result; 0 on timeout.
- out_err_o  output  1  1 = job aborted by timeout.
- done_cnt_o  output  CNT_WIDTH  count of results handed downstream, including errored ones.

Behaviour:
- Reset (synchronous): state IDLE, in_ready_o=1, core_start_o=0, core_a_o=core_b_o=0, out_valid_o=0, out_result_o=0, out_err_o=0, done_cnt_o=0, timeout counter 0. Reset in any state, including mid-WAIT or mid-DRAIN, drops the job silently with no output.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, register in_a_i/in_b_i into core_a_o/core_b_o and go to ISSUE.
  - ISSUE: core_start_o=1 for exactly this one cycle. Clear the timeout counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - On core_valid_i: capture core_result_i into out_result_o, set out_err_o=0, out_valid_o=1, go to DRAIN.
    - Else if counter == TIMEOUT_CYCLES-1: out_result_o=0, out_err_o=1, out_valid_o=1, go to DRAIN.
    - If core_valid_i arrives in the same cycle as the timeout, valid wins (no error).
  - DRAIN: hold out_* stable. On out_ready_i: out_valid_o=0, done_cnt_o += 1 (wraps at 2^CNT_WIDTH), go to IDLE.
- in_ready_o is 1 only in IDLE; no new pair is accepted until the previous result is consumed.
- Latency: pair accepted at edge N; core_start_o high in cycle N+1. The earliest core_valid_i that is honoured is in cycle N+2. out_valid_o rises the cycle after core_valid_i.
- core_a_o/core_b_o hold from the accept edge until the next accept; they never change while the core is working.
- core_valid_i outside WAIT (late pulse after timeout, spurious pulse in IDLE/ISSUE/DRAIN) is ignored; no state, output or counter change.
- core_busy_i does not affect control flow.
- in_valid_i outside IDLE is not accepted; upstream holds its data.
- Operands are passed through unmodified. Zero operands are the core's responsibility.

Test Plan:
- Basic job: send (48,18); core model returns 6 four cycles after start -> exactly one core_start_o pulse, core_a_o=48/core_b_o=18 stable throughout; out_valid_o=1, out_result_o=6, out_err_o=0; done_cnt_o=1 after handshake.
- Backpressure: hold out_ready_i=0 for 10 cycles after result (35,21)->7 -> out_result_o stays 7, in_ready_o=0 and a pending upstream pair is not taken until out_ready_i=1.
- Timeout: TIMEOUT_CYCLES=8, core never responds -> out_valid_o rises 8 cycles after start with out_result_o=0, out_err_o=1. A core_valid_i pulse injected 3 cycles later is ignored; the next job (12,8)->4 completes normally.
- Timeout tie: core_valid_i asserted exactly at counter==TIMEOUT_CYCLES-1 with result 5 -> out_result_o=5, out_err_o=0.
- Reset mid-WAIT: assert rst_i for 1 cycle during WAIT -> next cycle all outputs at reset values, done_cnt_o=0; the subsequent core_valid_i is ignored.
- Back-to-back and counter wrap: CNT_WIDTH=2, five jobs with out_ready_i tied 1 -> done_cnt_o sequence 1,2,3,0,1; one start pulse per job.

Source files
------------

// File: rtl/gcd_req.sv
// gcd_req: initiator for the gcd core's start/busy/valid interface.
// Accepts one operand pair upstream, issues it with a one-cycle start pulse,
// waits for the result under a watchdog and presents it downstream.
module gcd_req #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // upstream operand stream
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  // core interface
  output logic                 core_start_o,
  output logic [WIDTH-1:0]     core_a_o,
  output logic [WIDTH-1:0]     core_b_o,
  input  logic                 core_busy_i,
  input  logic                 core_valid_i,
  input  logic [WIDTH-1:0]     core_result_i,
  // downstream result stream
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_result_o,
  output logic                 out_err_o,
  output logic [CNT_WIDTH-1:0] done_cnt_o
);

  // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LP_CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_in_ready;
  logic                 r_core_start;
  logic [WIDTH-1:0]     r_core_a;
  logic [WIDTH-1:0]     r_core_b;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_result;
  logic                 r_out_err;
  logic [CNT_WIDTH-1:0] r_done_cnt;
  logic [TW-1:0]        r_tmo_cnt;

  logic                 w_cnt_last;
  logic                 w_accept;
  logic                 w_done_ok;
  logic                 w_done_tmo;
  logic                 w_pop;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;

  // The core's busy flag is observed only; it never steers control flow.
  logic                 w_unused_busy;
  assign w_unused_busy = core_busy_i;

  assign w_cnt_last = (r_tmo_cnt == LP_CNT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a valid in the timeout cycle still completes cleanly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (core_valid_i || w_cnt_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath enables; core_valid outside WAIT is ignored here.
  always_comb begin
    w_accept   = 1'b0;
    w_done_ok  = 1'b0;
    w_done_tmo = 1'b0;
    w_pop      = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = in_valid_i;
      S_ISSUE: w_cnt_clr = 1'b1;
      S_WAIT: begin
        w_cnt_inc  = 1'b1;
        w_done_ok  = core_valid_i;
        w_done_tmo = ~core_valid_i & w_cnt_last;
      end
      S_DRAIN: w_pop = out_ready_i;
      default: ;
    endcase
  end

  // Handshake/strobe outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_ready   <= 1'b1;
      r_core_start <= 1'b0;
    end else begin
      r_in_ready   <= (w_state_nxt == S_IDLE);
      r_core_start <= (w_state_nxt == S_ISSUE);
    end
  end

  // Operands latch only on accept so they stay put while the core works.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_core_a <= '0;
      r_core_b <= '0;
    end else if (w_accept) begin
      r_core_a <= in_a_i;
      r_core_b <= in_b_i;
    end
  end

  // Watchdog counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_tmo_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Result register: loaded on completion or timeout, held through DRAIN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
    end else if (w_done_ok) begin
      r_out_valid  <= 1'b1;
      r_out_result <= core_result_i;
      r_out_err    <= 1'b0;
    end else if (w_done_tmo) begin
      r_out_valid  <= 1'b1;
      r_out_result <= '0;
      r_out_err    <= 1'b1;
    end else if (w_pop) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Completed-job counter, wraps naturally; errored jobs count too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done_cnt <= '0;
    end else if (w_pop) begin
      r_done_cnt <= r_done_cnt + CNT_WIDTH'(1);
    end
  end

  assign in_ready_o   = r_in_ready;
  assign core_start_o = r_core_start;
  assign core_a_o     = r_core_a;
  assign core_b_o     = r_core_b;
  assign out_valid_o  = r_out_valid;
  assign out_result_o = r_out_result;
  assign out_err_o    = r_out_err;
  assign done_cnt_o   = r_done_cnt;

endmodule

// File: tb/tb_gcd_req.sv
// Directed bench for gcd_req; the core is modelled by the stimulus tasks.
module tb_gcd_req;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TMO   = 8;
  localparam int unsigned CW    = 2;

  logic             clk;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_a_i;
  logic [WIDTH-1:0] in_b_i;
  logic             core_start_o;
  logic [WIDTH-1:0] core_a_o;
  logic [WIDTH-1:0] core_b_o;
  logic             core_busy_i;
  logic             core_valid_i;
  logic [WIDTH-1:0] core_result_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_result_o;
  logic             out_err_o;
  logic [CW-1:0]    done_cnt_o;

  int n_vec  = 0;
  int n_err  = 0;
  int starts = 0;
  logic [CW-1:0] exp_cnt = '0;

  gcd_req #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i),
    .core_start_o(core_start_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_busy_i(core_busy_i), .core_valid_i(core_valid_i),
    .core_result_i(core_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_err_o(out_err_o),
    .done_cnt_o(done_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses mid-cycle.
  always @(negedge clk) if (core_start_o === 1'b1) starts = starts + 1;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair for one edge; returns in the ISSUE cycle.
  task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid_i = 1'b1; in_a_i = a; in_b_i = b;
    tick();
    in_valid_i = 1'b0;
  endtask

  // One-cycle core result pulse; returns in the following cycle.
  task automatic core_pulse(input logic [WIDTH-1:0] r);
    core_valid_i = 1'b1; core_busy_i = 1'b0; core_result_i = r;
    tick();
    core_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    exp_cnt = '0;
    n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready_o); end
    n_vec++; if (core_start_o !== 1'b0) begin n_err++; $display("FAIL reset_start got %0b exp 0", core_start_o); end
    n_vec++; if (core_a_o !== 32'd0 || core_b_o !== 32'd0) begin n_err++; $display("FAIL reset_ops got %0d/%0d exp 0/0", core_a_o, core_b_o); end
    n_vec++; if (out_valid_o !== 1'b0 || out_err_o !== 1'b0) begin n_err++; $display("FAIL reset_out got v%0b e%0b exp v0 e0", out_valid_o, out_err_o); end
    n_vec++; if (out_result_o !== 32'd0) begin n_err++; $display("FAIL reset_result got %0d exp 0", out_result_o); end
    n_vec++; if (done_cnt_o !== 2'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", done_cnt_o); end
  endtask

  task automatic test_basic();
    int s0;
    s0 = starts;
    send_pair(32'd48, 32'd18);
    n_vec++; if (core_start_o !== 1'b1) begin n_err++; $display("FAIL basic_start got %0b exp 1", core_start_o); end
    n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_in_ready got %0b exp 0", in_ready_o); end
    in_a_i = 32'd1; in_b_i = 32'd1;
    core_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (core_a_o !== 32'd48 || core_b_o !== 32'd18) begin n_err++; $display("FAIL basic_ops_stable got %0d/%0d exp 48/18", core_a_o, core_b_o); end
      n_vec++; if (core_start_o !== 1'b0 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_wait got s%0b v%0b exp s0 v0", core_start_o, out_valid_o); end
    end
    core_pulse(32'd6);
    n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd6 || out_err_o !== 1'b0) begin n_err++; $display("FAIL basic_result got v%0b r%0d e%0b exp v1 r6 e0", out_valid_o, out_result_o, out_err_o); end
    n_vec++; if (starts - s0 !== 1) begin n_err++; $display("FAIL basic_start_count got %0d exp 1", starts - s0); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (out_valid_o !== 1'b0 || done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL basic_drain got v%0b c%0d exp v0 c%0d", out_valid_o, done_cnt_o, exp_cnt); end
    n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_idle got %0b exp 1", in_ready_o); end
  endtask

  task automatic test_backpressure();
    send_pair(32'd35, 32'd21);
    tick(); tick();
    core_pulse(32'd7);
    in_valid_i = 1'b1; in_a_i = 32'd99; in_b_i = 32'd77;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd7) begin n_err++; $display("FAIL bp_hold got v%0b r%0d exp v1 r7", out_valid_o, out_result_o); end
      n_vec++; if (in_ready_o !== 1'b0 || core_a_o !== 32'd35) begin n_err++; $display("FAIL bp_no_accept got rdy%0b a%0d exp rdy0 a35", in_ready_o, core_a_o); end
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (in_ready_o !== 1'b1 || done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL bp_release got rdy%0b c%0d exp rdy1 c%0d", in_ready_o, done_cnt_o, exp_cnt); end
    tick();
    in_valid_i = 1'b0;
    n_vec++; if (core_start_o !== 1'b1 || core_a_o !== 32'd99 || core_b_o !== 32'd77) begin n_err++; $display("FAIL bp_pending got s%0b %0d/%0d exp s1 99/77", core_start_o, core_a_o, core_b_o); end
    tick();
    core_pulse(32'd11);
    n_vec++; if (out_result_o !== 32'd11 || out_err_o !== 1'b0) begin n_err++; $display("FAIL bp_second got r%0d e%0b exp r11 e0", out_result_o, out_err_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL bp_cnt got %0d exp %0d", done_cnt_o, exp_cnt); end
  endtask

  task automatic test_timeout();
    send_pair(32'd1, 32'd2);
    // WAIT runs TMO cycles (counter 0..TMO-1) starting the cycle after start.
    for (int i = 0; i < TMO; i++) tick();
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL tmo_early got %0b exp 0", out_valid_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd0 || out_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_flag got v%0b r%0d e%0b exp v1 r0 e1", out_valid_o, out_result_o, out_err_o); end
    tick(); tick(); tick();
    core_pulse(32'd123);
    n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd0 || out_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_late_pulse got v%0b r%0d e%0b exp v1 r0 e1", out_valid_o, out_result_o, out_err_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL tmo_cnt got %0d exp %0d", done_cnt_o, exp_cnt); end
    core_pulse(32'd55);
    n_vec++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL idle_spurious got rdy%0b v%0b c%0d exp rdy1 v0 c%0d", in_ready_o, out_valid_o, done_cnt_o, exp_cnt); end
    send_pair(32'd12, 32'd8);
    core_pulse(32'd99);
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL issue_spurious got %0b exp 0", out_valid_o); end
    tick();
    core_pulse(32'd4);
    n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd4 || out_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_next_job got v%0b r%0d e%0b exp v1 r4 e0", out_valid_o, out_result_o, out_err_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL tmo_next_cnt got %0d exp %0d", done_cnt_o, exp_cnt); end
  endtask

  task automatic test_timeout_tie();
    send_pair(32'd20, 32'd15);
    for (int i = 0; i < TMO; i++) tick();
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL tie_early got %0b exp 0", out_valid_o); end
    core_pulse(32'd5);
    n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== 32'd5 || out_err_o !== 1'b0) begin n_err++; $display("FAIL tie_valid_wins got v%0b r%0d e%0b exp v1 r5 e0", out_valid_o, out_result_o, out_err_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_vec++; if (done_cnt_o !== exp_cnt) begin n_err++; $display("FAIL tie_cnt got %0d exp %0d", done_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    send_pair(32'd9, 32'd6);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_cnt = '0;
    n_vec++; if (in_ready_o !== 1'b1 || core_start_o !== 1'b0 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL rstw_ctrl got rdy%0b s%0b v%0b exp rdy1 s0 v0", in_ready_o, core_start_o, out_valid_o); end
    n_vec++; if (core_a_o !== 32'd0 || core_b_o !== 32'd0 || out_result_o !== 32'd0 || out_err_o !== 1'b0) begin n_err++; $display("FAIL rstw_data got %0d/%0d r%0d e%0b exp 0/0 r0 e0", core_a_o, core_b_o, out_result_o, out_err_o); end
    n_vec++; if (done_cnt_o !== 2'd0) begin n_err++; $display("FAIL rstw_cnt got %0d exp 0", done_cnt_o); end
    core_pulse(32'd3);
    n_vec++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_result_o !== 32'd0) begin n_err++; $display("FAIL rstw_late_pulse got v%0b rdy%0b r%0d exp v0 rdy1 r0", out_valid_o, in_ready_o, out_result_o); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a_v [5];
    logic [WIDTH-1:0] b_v [5];
    logic [WIDTH-1:0] r_v [5];
    logic [CW-1:0]    c_v [5];
    int s0;
    a_v = '{32'd10, 32'd14, 32'd27, 32'd100, 32'd17};
    b_v = '{32'd4,  32'd21, 32'd18, 32'd75,  32'd5};
    r_v = '{32'd2,  32'd7,  32'd9,  32'd25,  32'd1};
    c_v = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    s0 = starts;
    out_ready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      send_pair(a_v[j], b_v[j]);
      tick();
      core_pulse(r_v[j]);
      n_vec++; if (out_valid_o !== 1'b1 || out_result_o !== r_v[j]) begin n_err++; $display("FAIL b2b_result[%0d] got v%0b r%0d exp v1 r%0d", j, out_valid_o, out_result_o, r_v[j]); end
      tick();
      n_vec++; if (done_cnt_o !== c_v[j]) begin n_err++; $display("FAIL b2b_cnt[%0d] got %0d exp %0d", j, done_cnt_o, c_v[j]); end
    end
    out_ready_i = 1'b0;
    n_vec++; if (starts - s0 !== 5) begin n_err++; $display("FAIL b2b_starts got %0d exp 5", starts - s0); end
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0;
    core_busy_i = 1'b0; core_valid_i = 1'b0; core_result_i = '0;
    out_ready_i = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached");
    $fatal(1, "time limit");
  end

endmodule
